urv_writeback: RTL

Writeback stage of the uRV pipeline. It consumes the X/W pipeline registers produced by the execute stage, the shifter and multiplier results, and load data from the data-memory port. It selects and formats the destination value and drives the register-file write port, including the ECC flip bits. For loads and stores it tracks the outstanding memory access, stalls the pipeline until the access completes, and reports a bus error on timeout.

---
 rtl/urv_writeback_pkg.sv | 26 ++
 rtl/urv_writeback_load_align.sv | 30 +++
 rtl/urv_writeback.sv | 116 +++++++++++
 3 files changed

// File: rtl/urv_writeback_pkg.sv
// urv_writeback_pkg: shared encodings for the uRV writeback stage.
package urv_writeback_pkg;

    // Result source select carried in the X/W register.
    localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
    localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
    localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;
    localparam logic [1:0] RD_SOURCE_LOAD     = 2'd3;

    // Load/store width and sign codes (funct3 of the instruction).
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    // Exception cause raised by the exception unit on a memory timeout.
    localparam logic [3:0] CAUSE_BUS_ERROR = 4'd5;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WAIT = 2'd1,
        WB_HOLD = 2'd2
    } wb_state_t;

endpackage

// File: rtl/urv_writeback_load_align.sv
// urv_writeback_load_align: extracts a byte/halfword/word from a load word with sign or zero extension.
//   data_i  : raw 32-bit word from memory (or the holding register)
//   addr_i  : low address bits selecting the byte/halfword lane
//   fun_i   : LDST_* width/sign code
//   value_o : formatted result
//   valid_o : fun_i is a legal load code
module urv_writeback_load_align
    import urv_writeback_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  fun_i,
    output logic [31:0] value_o,
    output logic        valid_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = data_i[{addr_i, 3'b000} +: 8];
        h       = addr_i[1] ? data_i[31:16] : data_i[15:0];
        value_o = fun_i == LDST_B  ? {{24{b[7]}}, b}  :
                  fun_i == LDST_BU ? {24'h0, b}       :
                  fun_i == LDST_H  ? {{16{h[15]}}, h} :
                  fun_i == LDST_HU ? {16'h0, h}       : data_i;
        valid_o = fun_i inside {LDST_B, LDST_BU, LDST_H, LDST_HU, LDST_L};
    end

endmodule

// File: rtl/urv_writeback.sv
// urv_writeback: uRV writeback stage; selects/format the result, drives the RF write port, tracks memory accesses.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   w_stall_i               : global pipeline stall
//   w_stall_req_o           : stall request while a memory access is outstanding
//   x_*_i                   : X/W pipeline register fields plus shifter/multiplier results
//   dm_data_l_i, dm_*_done_i: data-memory load data and completion strobes
//   rf_*_o                  : register-file write port (value doubles as bypass)
//   w_bus_err_o             : one-cycle pulse when a memory access times out
module urv_writeback
    import urv_writeback_pkg::*;
#(
    parameter int g_mem_timeout = 255,
    parameter int g_with_hw_mul = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        w_stall_i,
    output logic        w_stall_req_o,
    input  logic        x_valid_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [2:0]  x_fun_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] x_shifter_rd_value_i,
    input  logic [31:0] x_multiply_rd_value_i,
    input  logic [1:0]  x_ecc_flip_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic [1:0]  rf_ecc_flip_o,
    output logic        w_bus_err_o
);

    localparam int CW = g_mem_timeout > 0 ? $clog2(g_mem_timeout + 1) : 1;

    wb_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hold_q, hold_d;
    logic [31:0]   ld_value;
    logic          ld_ok, mem_op, done, start, tmo, load_fin;
    logic          unused_addr;

    assign unused_addr = ^x_dm_addr_i[31:2];
    assign mem_op      = x_valid_i & (x_load_i | x_store_i);
    // A load flag wins when both flags are set, so it also picks the matching done.
    assign done        = x_load_i ? dm_load_done_i : dm_store_done_i;
    assign start       = state_q == WB_IDLE && mem_op && !w_stall_i;
    // cnt_q counts completed WAIT cycles, so this fires on the g_mem_timeout-th one; done wins.
    assign tmo         = g_mem_timeout != 0 && state_q == WB_WAIT && !done && cnt_q == CW'(g_mem_timeout - 1);

    urv_writeback_load_align u_align (
        .data_i  (state_q == WB_HOLD ? hold_q : dm_data_l_i),
        .addr_i  (x_dm_addr_i[1:0]),
        .fun_i   (x_fun_i),
        .value_o (ld_value),
        .valid_o (ld_ok)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        hold_d  = hold_q;
        case (state_q)
            WB_IDLE: if (start && !done) state_d = WB_WAIT;
            WB_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (done && w_stall_i) begin
                    state_d = WB_HOLD;
                    hold_d  = dm_data_l_i;
                end else if (done || tmo) begin
                    state_d = WB_IDLE;
                    cnt_d   = '0;
                end
            end
            WB_HOLD: if (!w_stall_i) state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    // Outputs are gated by rst_n_i so they read zero for the whole reset, not just after an edge.
    always_comb begin
        load_fin      = x_load_i & ((start & done) |
                                    (state_q == WB_WAIT & done & !w_stall_i) |
                                    (state_q == WB_HOLD & !w_stall_i));
        rf_rd_write_o = rst_n_i & x_valid_i & x_rd_write_i & ((!mem_op & !w_stall_i) | (load_fin & ld_ok));
        w_stall_req_o = rst_n_i & ((start & !done) | (state_q == WB_WAIT & !done & !tmo));
        w_bus_err_o   = rst_n_i & tmo;
        rf_rd_o       = rst_n_i ? x_rd_i : '0;
        rf_rd_value_o = !rst_n_i ? '0 :
                        (x_load_i | (x_rd_source_i == RD_SOURCE_LOAD)) ? ld_value :
                        x_rd_source_i == RD_SOURCE_SHIFTER ? x_shifter_rd_value_i :
                        x_rd_source_i == RD_SOURCE_MULTIPLY ? (g_with_hw_mul != 0 ? x_multiply_rd_value_i : '0) :
                        x_rd_value_i;
        rf_ecc_flip_o = rf_rd_write_o ? x_ecc_flip_i : '0;
    end

endmodule
